usb_tx_encoder: RTL

//  Transmit end of the USB full-speed data line. Serializes bytes LSB-first, prepends SYNC,
//  bit-stuffs, NRZI-encodes, and drives d_plus/d_minus. Ends every packet with EOP.

---
 rtl/usb_tx_encoder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC, LSB-first serialisation, bit stuffing,
// NRZI line coding and EOP, fed through a one-byte valid/ready holding register.
`timescale 1ns/1ps
module usb_tx_encoder #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic       d_plus,
  output logic       d_minus
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DATA, S_STUFF, S_EOP_SE0, S_EOP_J
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      bitcnt_q;
  logic [2:0]      ones_q;
  logic [7:0]      shift_q;
  logic            cur_last_q;
  logic [7:0]      hold_data_q;
  logic            hold_last_q;
  logic            full_q;
  logic            ready_q;
  logic            busy_q;
  logic            underrun_q;
  logic            dp_q;
  logic            dm_q;

  logic            wrap;
  logic            byte_end;
  logic [2:0]      nxt_idx;
  logic            advance;
  logic            load;
  logic            accept;
  logic            full_d;
  logic            emit_bit;
  logic [2:0]      ones_inc;

  always_comb begin
    wrap     = (timer_q == TW'(CLKS_PER_BIT - 1));
    byte_end = (bitcnt_q == 3'd7);
    nxt_idx  = bitcnt_q + 3'd1;
    advance  = wrap && ((state_q == S_DATA && ones_q != 3'd6) || state_q == S_STUFF);
    load     = (state_q == S_IDLE && full_q) || (advance && byte_end && full_q);
    accept   = tx_valid && ready_q;
    full_d   = accept || (full_q && !load);
    emit_bit = byte_end ? hold_data_q[0] : shift_q[nxt_idx];
    ones_inc = (ones_q == 3'd6) ? 3'd6 : ones_q + 3'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bitcnt_q    <= '0;
      ones_q      <= '0;
      shift_q     <= '0;
      cur_last_q  <= 1'b0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      full_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      dp_q        <= 1'b1;
      dm_q        <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      full_q     <= full_d;
      ready_q    <= !full_d;
      if (accept) begin
        hold_data_q <= tx_data;
        hold_last_q <= tx_last;
      end
      if (state_q != S_IDLE) timer_q <= wrap ? '0 : timer_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (full_q) begin
            state_q    <= S_SYNC;
            busy_q     <= 1'b1;
            shift_q    <= hold_data_q;
            cur_last_q <= hold_last_q;
            bitcnt_q   <= '0;
            ones_q     <= '0;
            timer_q    <= '0;
            dp_q       <= dm_q;
            dm_q       <= dp_q;
          end
        end
        S_SYNC: begin
          if (wrap) begin
            if (!byte_end) begin
              bitcnt_q <= nxt_idx;
              if (bitcnt_q != 3'd6) begin
                dp_q <= dm_q;
                dm_q <= dp_q;
              end
            end else begin
              // The trailing SYNC 1 is already counted, so a leading data 1 makes two.
              state_q  <= S_DATA;
              bitcnt_q <= '0;
              if (shift_q[0]) begin
                ones_q <= 3'd2;
              end else begin
                ones_q <= '0;
                dp_q   <= dm_q;
                dm_q   <= dp_q;
              end
            end
          end
        end
        S_DATA, S_STUFF: begin
          if (wrap) begin
            if (state_q == S_DATA && ones_q == 3'd6) begin
              state_q <= S_STUFF;
              ones_q  <= '0;
              dp_q    <= dm_q;
              dm_q    <= dp_q;
            end else if (!byte_end || full_q) begin
              state_q <= S_DATA;
              if (byte_end) begin
                shift_q    <= hold_data_q;
                cur_last_q <= hold_last_q;
                bitcnt_q   <= '0;
              end else begin
                bitcnt_q <= nxt_idx;
              end
              if (emit_bit) begin
                ones_q <= ones_inc;
              end else begin
                ones_q <= '0;
                dp_q   <= dm_q;
                dm_q   <= dp_q;
              end
            end else begin
              state_q    <= S_EOP_SE0;
              bitcnt_q   <= '0;
              dp_q       <= 1'b0;
              dm_q       <= 1'b0;
              underrun_q <= !cur_last_q;
            end
          end
        end
        S_EOP_SE0: begin
          if (wrap) begin
            if (bitcnt_q == 3'd0) begin
              bitcnt_q <= 3'd1;
            end else begin
              state_q <= S_EOP_J;
              dp_q    <= 1'b1;
              dm_q    <= 1'b0;
            end
          end
        end
        S_EOP_J: begin
          if (wrap) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            bitcnt_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_ready    = ready_q;
  assign tx_busy     = busy_q;
  assign tx_underrun = underrun_q;
  assign d_plus      = dp_q;
  assign d_minus     = dm_q;

endmodule
